// File: rtl/clkgen_frac.sv
// clkgen_frac: multi-channel fractional clock-enable generator.
// Each channel accumulates MUL per unheld cycle and fires a CE strobe whenever
// the accumulator crosses DIV. The average CE rate is therefore CLK*MUL/DIV.
// A PHASES-deep phase counter steps on every strobe and steers a one-hot PH_STB.
// Optional feature macro: CLKGEN_CFG_EN. It enables runtime ratio writes through
// CFG_WE/CFG_CH/CFG_MUL/CFG_DIV with a per-channel pending slot (CFG_PEND).
// A pending ratio is applied on the channel's next hit. It is applied at once
// if the current MUL is zero.
module clkgen_frac #(
    parameter int                NCH      = 3,
    parameter int                AW       = 10,
    parameter int                PHASES   = 4,
    parameter logic [NCH*AW-1:0] MUL_INIT = {10'd1, 10'd22, 10'd88},
    parameter logic [NCH*AW-1:0] DIV_INIT = {10'd7, 10'd105, 10'd315},
    localparam int               PW       = $clog2(PHASES),
    localparam int               CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  CLK,
    input  logic                  RESB,
    input  logic [NCH-1:0]        HOLD,
    output logic [NCH-1:0]        CE,
    output logic [NCH*PHASES-1:0] PH_STB,
    output logic [NCH*PW-1:0]     PHASE
`ifdef CLKGEN_CFG_EN
    ,
    input  logic                  CFG_WE,
    input  logic [CW-1:0]         CFG_CH,
    input  logic [AW-1:0]         CFG_MUL,
    input  logic [AW-1:0]         CFG_DIV,
    output logic [NCH-1:0]        CFG_PEND
`endif
);

`ifdef CLKGEN_CFG_EN
    // A write is accepted only when the ratio is legal and the channel exists.
    // Rejected writes leave every pending slot untouched.
    logic cfg_ok;

    // Qualify the incoming ratio write.
    always_comb begin
        cfg_ok = CFG_WE;
        if (CFG_DIV == '0) begin
            cfg_ok = 1'b0;
        end
        if (CFG_MUL > CFG_DIV) begin
            cfg_ok = 1'b0;
        end
        if (32'(CFG_DIV) > (32'd1 << (AW - 1))) begin
            cfg_ok = 1'b0;
        end
        if (32'(CFG_CH) >= 32'(NCH)) begin
            cfg_ok = 1'b0;
        end
    end
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [AW-1:0]     acc;
        logic [AW-1:0]     mul;
        logic [AW-1:0]     dvs;
        logic [AW-1:0]     nxt;
        logic              hit;
        logic [PW-1:0]     ph;
        logic              ce_r;
        logic [PHASES-1:0] stb_r;

        // acc < DIV and MUL <= DIV <= 2^(AW-1), so the sum fits in AW bits.
        assign nxt = acc + mul;
        assign hit = (nxt >= dvs);

        // Accumulator, phase counter and registered strobes.
        // HOLD freezes acc and phase and forces the strobes low.
        always_ff @(posedge CLK or negedge RESB) begin
            if (!RESB) begin
                acc   <= '0;
                ph    <= '0;
                ce_r  <= 1'b0;
                stb_r <= '0;
            end else if (HOLD[c]) begin
                ce_r  <= 1'b0;
                stb_r <= '0;
            end else begin
                acc   <= hit ? (nxt - dvs) : nxt;
                ce_r  <= hit;
                stb_r <= hit ? (PHASES'(1) << ph) : '0;
                if (hit) begin
                    ph <= ph + PW'(1);
                end
            end
        end

`ifdef CLKGEN_CFG_EN
        logic [AW-1:0] pmul;
        logic [AW-1:0] pdiv;
        logic          pend;
        logic          wr;
        logic          apply;

        assign wr    = cfg_ok && (CFG_CH == CW'(c));
        // The hit cycle wraps acc with the old ratio. The new ratio takes
        // effect on the following cycle. A zero multiplier never hits, so the
        // pending ratio is taken straight away in that case.
        assign apply = pend && ((hit && !HOLD[c]) || (mul == '0));

        // Active ratio and pending slot.
        // A write in the same cycle as an apply stays pending.
        always_ff @(posedge CLK or negedge RESB) begin
            if (!RESB) begin
                mul  <= MUL_INIT[c*AW +: AW];
                dvs  <= DIV_INIT[c*AW +: AW];
                pmul <= '0;
                pdiv <= '0;
                pend <= 1'b0;
            end else begin
                if (apply) begin
                    mul <= pmul;
                    dvs <= pdiv;
                end
                if (wr) begin
                    pend <= 1'b1;
                    pmul <= CFG_MUL;
                    pdiv <= CFG_DIV;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign CFG_PEND[c] = pend;
`else
        assign mul = MUL_INIT[c*AW +: AW];
        assign dvs = DIV_INIT[c*AW +: AW];
`endif

        assign CE[c]                     = ce_r;
        assign PH_STB[c*PHASES +: PHASES] = stb_r;
        assign PHASE[c*PW +: PW]          = ph;
    end

endmodule
